// File: rtl/data_transmitter.sv
// Serial word transmitter: fetches words from memory and sends them LSB-first on DAI/DEN.
// Optional even-parity bit per word when DATA_TRANSMITTER_PARITY_EN is defined.
module data_transmitter #(
    parameter int unsigned GAP = 2
) (
    input  logic        DCK,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  word_cnt,
    output logic        rd_en,
    output logic [9:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        DAI,
    output logic        DEN,
    output logic        busy,
    output logic        done
);

`ifdef DATA_TRANSMITTER_PARITY_EN
    localparam logic [4:0] BitLast = 5'd16;
`else
    localparam logic [4:0] BitLast = 5'd15;
`endif
    localparam logic [3:0] GapLast  = 4'(GAP - 1);
    localparam logic [3:0] GapFetch = 4'(GAP - 2);

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StShift, StGap} state_e;

    state_e      r_state;
    logic [9:0]  r_words;
    logic [9:0]  r_addr;
    logic [15:0] r_shreg;
    logic [4:0]  r_bit_cnt;
    logic [3:0]  r_gap_cnt;
    logic        r_rd_en;
    logic        r_dai;
    logic        r_den;
    logic        r_busy;
    logic        r_done;
`ifdef DATA_TRANSMITTER_PARITY_EN
    logic        r_parity;
`endif

    logic w_load;

    // A word is captured either after the initial FETCH/LOAD or in the last GAP cycle
    always_comb begin
        w_load = (r_state == StLoad) ||
                 ((r_state == StGap) && (r_gap_cnt == GapLast) && (r_words != 10'd0));
    end

    always_ff @(posedge DCK or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_words   <= 10'd0;
            r_addr    <= 10'd0;
            r_shreg   <= 16'd0;
            r_bit_cnt <= 5'd0;
            r_gap_cnt <= 4'd0;
            r_rd_en   <= 1'b0;
            r_dai     <= 1'b0;
            r_den     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef DATA_TRANSMITTER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            if (r_rd_en) begin
                r_addr <= r_addr + 10'd1;
            end
            if (w_load) begin
                r_state   <= StShift;
                r_shreg   <= rd_data;
                r_dai     <= rd_data[0];
                r_den     <= 1'b1;
                r_bit_cnt <= 5'd0;
`ifdef DATA_TRANSMITTER_PARITY_EN
                r_parity  <= ^rd_data;
`endif
            end
            case (r_state)
                StIdle: begin
                    if (start) begin
                        if (word_cnt != 10'd0) begin
                            r_state <= StFetch;
                            r_words <= word_cnt;
                            r_addr  <= 10'd0;
                            r_rd_en <= 1'b1;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                StFetch: r_state <= StLoad;
                StLoad: ;
                StShift: begin
                    if (r_bit_cnt == BitLast) begin
                        r_state   <= StGap;
                        r_den     <= 1'b0;
                        r_dai     <= 1'b0;
                        r_gap_cnt <= 4'd0;
                        r_words   <= r_words - 10'd1;
                        r_rd_en   <= (GapFetch == 4'd0) && (r_words != 10'd1);
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                        r_shreg   <= r_shreg >> 1;
`ifdef DATA_TRANSMITTER_PARITY_EN
                        r_dai     <= (r_bit_cnt == 5'd15) ? r_parity : r_shreg[1];
`else
                        r_dai     <= r_shreg[1];
`endif
                    end
                end
                StGap: begin
                    if (r_gap_cnt == GapLast) begin
                        if (r_words == 10'd0) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                        r_rd_en   <= ((r_gap_cnt + 4'd1) == GapFetch) && (r_words != 10'd0);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_addr = r_addr;
    assign DAI     = r_dai;
    assign DEN     = r_den;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_data_transmitter.sv
// Self-checking bench for data_transmitter: per-cycle comparison against a timeline model
// computed from frame length, word period and memory contents.
module tb_data_transmitter;

    localparam int unsigned GAP = 2;
`ifdef DATA_TRANSMITTER_PARITY_EN
    localparam int S = 17;
`else
    localparam int S = 16;
`endif
    localparam int P = S + GAP;

    logic        DCK;
    logic        rst;
    logic        start;
    logic [9:0]  word_cnt;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data;
    logic        DAI;
    logic        DEN;
    logic        busy;
    logic        done;

    logic [15:0] mem [1024];
    int n_cmp = 0;
    int n_err = 0;

    data_transmitter #(.GAP(GAP)) u_dut (
        .DCK      (DCK),
        .rst      (rst),
        .start    (start),
        .word_cnt (word_cnt),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .DAI      (DAI),
        .DEN      (DEN),
        .busy     (busy),
        .done     (done)
    );

    initial DCK = 1'b0;
    always #5 DCK = ~DCK;

    // Synchronous memory; junk on rd_data when no read was issued
    always @(posedge DCK) begin
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= 16'($urandom);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {busy, done, rd_en, DEN, DAI} for cycle k after the start edge
    function automatic logic [4:0] expect_out(input int n, input int k);
        logic b, d, r, en, da;
        logic [15:0] w_data;
        int last, rel, w, bit_i;
        b = 0; d = 0; r = 0; en = 0; da = 0;
        if (n == 0) return (k == 1) ? 5'b01000 : 5'b00000;
        last = 3 + n * P;
        b = (k >= 1) && (k < last);
        d = (k == last);
        r = (k == 1) || ((k > 1) && ((k - 1) % P == 0) && ((k - 1) / P <= n - 1));
        if ((k >= 3) && (k < last)) begin
            rel = k - 3;
            w = rel / P;
            bit_i = rel % P;
            if (bit_i < S) begin
                en = 1;
                w_data = mem[w];
                da = (bit_i < 16) ? w_data[bit_i] : ^w_data;
            end
        end
        return {b, d, r, en, da};
    endfunction

    // Called just after a falling edge; start is seen at the next rising edge
    task automatic run_frame(input int n, input int repulse_k, input int abort_k);
        logic [4:0] exp;
        int last;
        last = (n == 0) ? 1 : 3 + n * P;
        start = 1'b1;
        word_cnt = 10'(n);
        @(posedge DCK);
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge DCK);
            exp = expect_out(n, k);
            check_eq($sformatf("n%0d k%0d outs", n, k), {27'b0, busy, done, rd_en, DEN, DAI},
                     {27'b0, exp});
            if (exp[2]) begin
                check_eq($sformatf("n%0d k%0d addr", n, k), {22'b0, rd_addr},
                         32'((k == 1) ? 0 : (k - 1) / P));
            end
            start = (k == repulse_k);
            word_cnt = 10'($urandom);
            if (k == abort_k) return;
        end
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        word_cnt = 10'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);

        repeat (2) @(negedge DCK);
        check_eq("reset outs", {27'b0, busy, done, rd_en, DEN, DAI}, 32'd0);
        check_eq("reset addr", {22'b0, rd_addr}, 32'd0);
        rst = 1'b0;

        mem[0] = 16'hA5C3;
        run_frame(1, 0, 0);

        mem[0] = 16'h0001; mem[1] = 16'h8000; mem[2] = 16'hFFFF;
        run_frame(3, 0, 0);

        run_frame(0, 0, 0);

        mem[0] = 16'($urandom); mem[1] = 16'($urandom);
        run_frame(2, 6, 0);

        // Reset during the 8th SHIFT cycle truncates the word
        run_frame(1, 0, 10);
        rst = 1'b1;
        #1;
        check_eq("async rst outs", {27'b0, busy, done, rd_en, DEN, DAI}, 32'd0);
        check_eq("async rst addr", {22'b0, rd_addr}, 32'd0);
        repeat (3) begin
            @(negedge DCK);
            check_eq("held rst outs", {27'b0, busy, done, rd_en, DEN, DAI}, 32'd0);
        end
        rst = 1'b0;
        mem[0] = 16'($urandom);
        run_frame(1, 0, 0);
        repeat (4) begin
            @(negedge DCK);
            check_eq("idle after rst", {27'b0, busy, done, rd_en, DEN, DAI}, 32'd0);
        end

        mem[0] = 16'h0007;
        run_frame(1, 0, 0);
        mem[0] = 16'h0003;
        run_frame(1, 0, 0);

        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(0, 5);
            for (int i = 0; i < 6; i++) mem[i] = 16'($urandom);
            run_frame(n, $urandom_range(0, 40), 0);
            repeat ($urandom_range(0, 3)) @(negedge DCK);
        end

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        run_frame(1023, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
